// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter sharing the main-memory port between I$ and D$ refills.
// Ports: ic_req_*/ic_resp_* (I$ read), dc_req_*/dc_resp_* (D$ read/write), mem_* (memory).
module riscv_mem_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ic_req_valid,
  output logic                  ic_req_ready,
  input  logic [ADDR_WIDTH-1:0] ic_req_addr,
  output logic                  ic_resp_valid,
  output logic [DATA_WIDTH-1:0] ic_resp_data,
  input  logic                  dc_req_valid,
  output logic                  dc_req_ready,
  input  logic [ADDR_WIDTH-1:0] dc_req_addr,
  input  logic                  dc_req_rnw,
  input  logic [DATA_WIDTH-1:0] dc_req_data,
  output logic                  dc_resp_valid,
  output logic [DATA_WIDTH-1:0] dc_resp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_rnw,
  output logic [DATA_WIDTH-1:0] mem_req_data,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP
  } state_t;

  state_t state;
  logic   last_dc;
  logic   grant_dc;
  logic   any_req;
  logic   win_dc;
  logic   idle;

  assign any_req = ic_req_valid | dc_req_valid;
  // On a tie the requester not served last time wins.
  assign win_dc  = dc_req_valid & (~ic_req_valid | ~last_dc);
  assign idle    = (state == IDLE) & ~reset;

  assign ic_req_ready = idle & ic_req_valid & ~win_dc;
  assign dc_req_ready = idle & win_dc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last_dc       <= 1'b0;
      grant_dc      <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_rnw   <= 1'b1;
      mem_req_data  <= '0;
      ic_resp_valid <= 1'b0;
      ic_resp_data  <= '0;
      dc_resp_valid <= 1'b0;
      dc_resp_data  <= '0;
    end else begin
      ic_resp_valid <= 1'b0;
      dc_resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant_dc      <= win_dc;
            last_dc       <= win_dc;
            mem_req_valid <= 1'b1;
            if (win_dc) begin
              mem_req_addr <= dc_req_addr;
              mem_req_rnw  <= dc_req_rnw;
              mem_req_data <= dc_req_data;
            end else begin
              mem_req_addr <= ic_req_addr;
              mem_req_rnw  <= 1'b1;
              mem_req_data <= '0;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (mem_req_rnw) begin
              state <= WAIT_RESP;
            end else begin
              // Writes complete on acceptance; no data comes back.
              dc_resp_valid <= 1'b1;
              dc_resp_data  <= '0;
              state         <= IDLE;
            end
          end
        end
        WAIT_RESP: begin
          if (mem_resp_valid) begin
            if (grant_dc) begin
              dc_resp_valid <= 1'b1;
              dc_resp_data  <= mem_resp_data;
            end else begin
              ic_resp_valid <= 1'b1;
              ic_resp_data  <= mem_resp_data;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Shares the single main-memory port of the Riscv151 between the instruction-cache refill path and the data-cache refill/writeback path. Each cache presents a valid/ready request. The arbiter grants one requester, issues one memory transaction, and returns the completion to the granted requester. Only one transaction is in flight at a time. Grant order between the two caches is round-robin.

## Interface
- ADDR_WIDTH, 28: line address width (byte address >> 4)
- DATA_WIDTH, 128: cache-line width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- ic_req_valid  in  1  icache read request
- ic_req_ready  out  1  request accepted this cycle
- ic_req_addr  in  ADDR_WIDTH  line address
- ic_resp_valid  out  1  one-cycle completion pulse
- ic_resp_data  out  DATA_WIDTH  read line
- dc_req_valid  in  1  dcache request
- dc_req_ready  out  1  request accepted this cycle
- dc_req_addr  in  ADDR_WIDTH  line address
- dc_req_rnw  in  1  1 = read, 0 = write
- dc_req_data  in  DATA_WIDTH  write line
- dc_resp_valid  out  1  one-cycle completion pulse (read and write)
- dc_resp_data  out  DATA_WIDTH  read line (0 for writes)
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_WIDTH
- mem_req_rnw  out  1
- mem_req_data  out  DATA_WIDTH
- mem_resp_valid  in  1  read data return
- mem_resp_data  in  DATA_WIDTH

## Operation
- FSM states: IDLE, ISSUE, WAIT_RESP. Reset state is IDLE.
- IDLE, request handshake: ic_req_ready/dc_req_ready are asserted combinationally only in IDLE, only to the winner.
  - Winner selection: if only one valid is high, that requester wins.
  - If both are high, the requester not recorded in last_grant wins. last_grant resets to IC, so dcache wins the first tie.
  - On handshake, latch addr/rnw/data (icache rnw = 1) and the grant id, update last_grant, and go to ISSUE.
- ISSUE: mem_req_valid = 1 with the latched fields, held stable until mem_req_ready.
  - On acceptance with rnw = 1: go to WAIT_RESP.
  - On acceptance with rnw = 0: go to IDLE and pulse dc_resp_valid next cycle with dc_resp_data = 0.
- WAIT_RESP: wait for mem_resp_valid.
  - On mem_resp_valid: register the data to the granted requester's resp_data, pulse its resp_valid next cycle, and go to IDLE.
- mem_resp_valid outside WAIT_RESP is ignored.
- Response routing: only the granted requester ever sees resp_valid. The other requester's resp_valid stays 0.
- Requesters may hold valid high while waiting. The arbiter never drops a latched request.
- reset mid-transaction (ISSUE or WAIT_RESP):
  - The transaction is abandoned with no resp_valid.
  - The FSM returns to IDLE and last_grant returns to IC.
  - A late memory response is ignored per the rule above.

## Timing
- Reset values: mem_req_valid = 0, ic/dc_resp_valid = 0, resp_data = 0, mem_req_addr/data = 0, mem_req_rnw = 1, ic/dc_req_ready = 0 while reset is high.
- mem_req_valid is driven from a register. For a request handshake in cycle T, mem_req_valid = 1 from T+1.
- Read completion: for mem_resp_valid in cycle R, resp_valid = 1 in R+1 only.
- Write completion: for mem handshake in cycle W, dc_resp_valid = 1 in W+1 only.
- FSM re-enters IDLE in the cycle resp_valid is high, so a new req_ready can occur in that same cycle.
- Back-to-back minimum: with mem_req_ready and mem_resp_valid each 1 cycle after, a read occupies 4 cycles: handshake T, issue T+1, resp T+2, pulse + next handshake T+3.
- A requester that lost arbitration is accepted in the next IDLE cycle, unless it dropped valid.

## Test plan
- Single icache read, addr 0x0000123, memory ready immediately, response 2 cycles later with data 0xDEADBEEF_...
  -> mem_req_valid at T+1 with rnw = 1, ic_resp_valid for exactly 1 cycle carrying the data, dc_resp_valid stays 0.
- Both valid at the same cycle after reset -> dcache granted first, icache second. Both held valid for 4 transactions -> grants alternate DC, IC, DC, IC.
- dcache write, addr 0x0000040, data 0x1111…, mem_req_ready held low 5 cycles
  -> mem_req_valid/addr/data stable all 5 cycles, dc_resp_valid one cycle after acceptance, no WAIT_RESP entered.
- Spurious mem_resp_valid while in IDLE and ISSUE -> no resp_valid on either port, FSM unaffected.
- reset asserted during WAIT_RESP, memory responds 2 cycles later
  -> no resp_valid, mem_req_valid = 0, next tie grants dcache.
- Random valid/ready/latency stress for 10k cycles
  -> every accepted request gets exactly one resp_valid in order, and mem_req fields never change while valid && !ready.
